// File: rtl/fpu_ret_queue.sv
// fpu_ret_queue: retire-side collector for the six FPU return lanes.
// Enabled lanes are packed in lane order into a circular FIFO of DEPTH
// 14-bit entries. Up to two entries per cycle drain towards retire.
// A registered stall tells the scheduler to stop issuing before the FIFO
// fills. Optional feature macro: FPU_RET_STICKY_EN. When it is defined,
// the block accumulates IEEE exception flags from dequeued entries on
// sticky_flags, and flags_clr clears them.
module fpu_ret_queue #(
    parameter int DEPTH     = 24,
    parameter int STALL_LVL = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [13:0]                  u1_ret,
    input  logic [13:0]                  u2_ret,
    input  logic [13:0]                  u3_ret,
    input  logic [13:0]                  u4_ret,
    input  logic [13:0]                  u5_ret,
    input  logic [13:0]                  u6_ret,
    input  logic                         u1_ret_en,
    input  logic                         u2_ret_en,
    input  logic                         u3_ret_en,
    input  logic                         u4_ret_en,
    input  logic                         u5_ret_en,
    input  logic                         u6_ret_en,
    output logic [13:0]                  out0_ret,
    output logic [13:0]                  out1_ret,
    output logic                         out0_en,
    output logic                         out1_en,
    input  logic                         out_rdy,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef FPU_RET_STICKY_EN
    output logic [4:0]                   sticky_flags,
    input  logic                         flags_clr,
`endif
    output logic                         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Advance a pointer by a small increment and wrap it modulo DEPTH.
    // DEPTH does not have to be a power of two.
    function automatic logic [PW-1:0] wrap_ptr(input logic [PW-1:0] p,
                                               input logic [3:0]    inc);
        int s;
        s = (int'(p) + int'(inc)) % DEPTH;
        return PW'(s);
    endfunction

    logic [13:0]   mem [DEPTH];
    logic [PW-1:0] hd_r;
    logic [PW-1:0] tl_r;
    logic [CW-1:0] count_r;
    logic          stall_r;
    logic          overflow_r;

    logic [13:0]   lane_ret_s [6];
    logic [5:0]    lane_en_s;
    logic [5:0]    lane_acc_s;
    logic [PW-1:0] wr_idx_s [6];
    logic [2:0]    run_s;
    logic [2:0]    nenq_s;
    logic [2:0]    nacc_s;
    logic [1:0]    ndeq_s;
    logic [CW:0]   free_s;
    logic          drop_s;
    logic [CW-1:0] count_next_s;
    logic [PW-1:0] hd1_s;
    logic          out0_en_s;
    logic          out1_en_s;
    logic [13:0]   out0_ret_s;
    logic [13:0]   out1_ret_s;
    logic [4:0]    deq_flags_s;

    assign lane_ret_s[0] = u1_ret;
    assign lane_ret_s[1] = u2_ret;
    assign lane_ret_s[2] = u3_ret;
    assign lane_ret_s[3] = u4_ret;
    assign lane_ret_s[4] = u5_ret;
    assign lane_ret_s[5] = u6_ret;
    assign lane_en_s     = {u6_ret_en, u5_ret_en, u4_ret_en,
                            u3_ret_en, u2_ret_en, u1_ret_en};

    // Head view. The data words are forced to zero while they are not
    // valid, so stale array contents never show on the outputs.
    always_comb begin
        out0_en_s  = (count_r != {CW{1'b0}});
        out1_en_s  = (count_r >= CW'(2));
        hd1_s      = wrap_ptr(hd_r, 4'd1);
        out0_ret_s = 14'd0;
        out1_ret_s = 14'd0;
        if (out0_en_s) begin
            out0_ret_s = mem[hd_r];
        end else begin
            out0_ret_s = 14'd0;
        end
        if (out1_en_s) begin
            out1_ret_s = mem[hd1_s];
        end else begin
            out1_ret_s = 14'd0;
        end
    end

    // Dequeue count, free space, lane compaction and the next occupancy.
    always_comb begin
        ndeq_s       = 2'd0;
        run_s        = 3'd0;
        nacc_s       = 3'd0;
        lane_acc_s   = 6'd0;
        deq_flags_s  = 5'd0;
        for (int k = 0; k < 6; k++) begin
            wr_idx_s[k] = tl_r;
        end
        if (out_rdy) begin
            ndeq_s = {1'b0, out0_en_s} + {1'b0, out1_en_s};
        end else begin
            ndeq_s = 2'd0;
        end
        // Slots freed by this cycle's dequeue can take new words.
        free_s = (CW+1)'(DEPTH) - {1'b0, count_r} + (CW+1)'(ndeq_s);
        for (int k = 0; k < 6; k++) begin
            wr_idx_s[k] = wrap_ptr(tl_r, {1'b0, run_s});
            if (lane_en_s[k]) begin
                // Lower lanes win when the FIFO is short of space.
                lane_acc_s[k] = ((CW+1)'(run_s) < free_s);
                run_s         = run_s + 3'd1;
            end else begin
                lane_acc_s[k] = 1'b0;
            end
            if (lane_acc_s[k]) begin
                nacc_s = nacc_s + 3'd1;
            end else begin
                nacc_s = nacc_s;
            end
        end
        nenq_s       = run_s;
        drop_s       = ((CW+1)'(nenq_s) > free_s);
        count_next_s = count_r - CW'(ndeq_s) + CW'(nacc_s);
        if (ndeq_s != 2'd0) begin
            deq_flags_s = out0_ret_s[4:0];
        end else begin
            deq_flags_s = 5'd0;
        end
        if (ndeq_s == 2'd2) begin
            deq_flags_s = deq_flags_s | out1_ret_s[4:0];
        end else begin
            deq_flags_s = deq_flags_s;
        end
    end

    // Storage array. It has no reset, because entries are only visible
    // while the occupancy says they are valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (lane_acc_s[k]) begin
                mem[wr_idx_s[k]] <= lane_ret_s[k];
            end
        end
    end

    // Pointers, occupancy, the stall register and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hd_r       <= {PW{1'b0}};
            tl_r       <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            stall_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            hd_r       <= wrap_ptr(hd_r, {2'b00, ndeq_s});
            tl_r       <= wrap_ptr(tl_r, {1'b0, nacc_s});
            count_r    <= count_next_s;
            stall_r    <= (int'(count_next_s) > STALL_LVL);
            overflow_r <= overflow_r | drop_s;
        end
    end

`ifdef FPU_RET_STICKY_EN
    logic [4:0] sticky_r;

    // Exception flag accumulator. Flags from this cycle's dequeue survive
    // a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_r <= 5'd0;
        end else if (flags_clr) begin
            sticky_r <= deq_flags_s;
        end else begin
            sticky_r <= sticky_r | deq_flags_s;
        end
    end

    assign sticky_flags = sticky_r;
`endif

    assign out0_ret = out0_ret_s;
    assign out1_ret = out1_ret_s;
    assign out0_en  = out0_en_s;
    assign out1_en  = out1_en_s;
    assign stall    = stall_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule
